// File: rtl/disp7_pkg.sv
// rtl/disp7_pkg.sv - segment codes and nibble decode shared by the 7-segment scan driver
// Segment codes are active-high and packed {a,b,c,d,e,f,g} with a in bit 6.
// Output polarity is applied by the top level, not here.
package disp7_pkg;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_B   = 7'b0011111;
    localparam logic [6:0] SEG_C   = 7'b1001110;
    localparam logic [6:0] SEG_D   = 7'b0111101;
    localparam logic [6:0] SEG_E   = 7'b1001111;
    localparam logic [6:0] SEG_F   = 7'b1000111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    function automatic logic [6:0] hex_decode(input logic [3:0] nibble);
        logic [6:0] code;
        code = SEG_OFF;
        case (nibble)
            4'h0: code = SEG_0;
            4'h1: code = SEG_1;
            4'h2: code = SEG_2;
            4'h3: code = SEG_3;
            4'h4: code = SEG_4;
            4'h5: code = SEG_5;
            4'h6: code = SEG_6;
            4'h7: code = SEG_7;
            4'h8: code = SEG_8;
            4'h9: code = SEG_9;
            4'hA: code = SEG_A;
            4'hB: code = SEG_B;
            4'hC: code = SEG_C;
            4'hD: code = SEG_D;
            4'hE: code = SEG_E;
            4'hF: code = SEG_F;
            default: code = SEG_OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational nibble to active-high abcdefg decoder
// Ports:
//   nibble  in  4  hex digit 0-F
//   seg     out 7  {a,b,c,d,e,f,g}, active-high, a = bit 6
module hex_to_7seg
    import disp7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_decode(nibble);

endmodule

// File: rtl/display_7seg_scan.sv
// rtl/display_7seg_scan.sv - time-multiplexed N-digit 7-segment scan driver with tear-free update
// Optional feature macro: LEADING_ZERO_BLANK_EN (auto-blank digits above the most
// significant nonzero nibble; digit 0 is never auto-blanked).
// Ports:
//   clk         in   1           system clock
//   reset       in   1           synchronous, active-high reset
//   load        in   1           1-cycle strobe: capture value/blank_mask/dp_mask
//   value       in   4*N         nibble i = digit i (digit 0 = rightmost)
//   blank_mask  in   N           1 = force digit i dark
//   dp_mask     in   N           1 = light decimal point of digit i
//   seg         out  7           {a,b,c,d,e,f,g}, a = bit 6, polarity per SEG_ACTIVE_LOW
//   dp          out  1           decimal point of active digit, polarity per SEG_ACTIVE_LOW
//   an          out  N           one-hot digit enable, polarity per AN_ACTIVE_LOW
//   digit_idx   out  IDX_W       digit currently driven
//   update_ack  out  1           1-cycle pulse: pending word became visible
module display_7seg_scan
    import disp7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    update_ack
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic                  SEG_INV    = (SEG_ACTIVE_LOW != 0);
    localparam logic                  AN_INV     = (AN_ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_IDLE   = {7{SEG_INV}};
    localparam logic [NUM_DIGITS-1:0] AN_IDLE    = {NUM_DIGITS{AN_INV}};
    localparam logic [PRE_W-1:0]      PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]      presc;
    logic                  terminal;
    logic                  boundary;

    logic [VAL_W-1:0]      pend_value;
    logic [NUM_DIGITS-1:0] pend_blank;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic                  pend_valid;

    logic [VAL_W-1:0]      shadow_value;
    logic [NUM_DIGITS-1:0] shadow_blank;
    logic [NUM_DIGITS-1:0] shadow_dp;

    logic [NUM_DIGITS-1:0] auto_blank;
    logic [NUM_DIGITS-1:0] eff_blank;
    logic [VAL_W-1:0]      value_sel;
    logic [NUM_DIGITS-1:0] eff_blank_sel;
    logic [NUM_DIGITS-1:0] user_blank_sel;
    logic [NUM_DIGITS-1:0] dp_sel;
    logic [3:0]            cur_nibble;
    logic [6:0]            cur_code;
    logic [6:0]            seg_on;
    logic                  dp_on;
    logic [NUM_DIGITS-1:0] an_on;

    assign terminal = (presc == PRE_LAST);
    assign boundary = terminal && (digit_idx == DIGIT_LAST);

    // Slot timing: one digit per REFRESH_DIV clocks, wrap to digit 0 ends the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc     <= '0;
            digit_idx <= '0;
        end else if (terminal) begin
            presc     <= '0;
            digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Double buffer. A load coincident with the boundary lands in pending after the
    // old pending word has been promoted, so it waits a full frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_value   <= '0;
            pend_blank   <= '0;
            pend_dp      <= '0;
            pend_valid   <= 1'b0;
            shadow_value <= '0;
            shadow_blank <= '0;
            shadow_dp    <= '0;
            update_ack   <= 1'b0;
        end else begin
            update_ack <= 1'b0;
            if (boundary && pend_valid) begin
                shadow_value <= pend_value;
                shadow_blank <= pend_blank;
                shadow_dp    <= pend_dp;
                pend_valid   <= 1'b0;
                update_ack   <= 1'b1;
            end
            if (load) begin
                pend_value <= value;
                pend_blank <= blank_mask;
                pend_dp    <= dp_mask;
                pend_valid <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; everything above the first nonzero nibble goes dark.
    always_comb begin
        logic seen;
        seen       = 1'b0;
        auto_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (shadow_value[4*i +: 4] != 4'h0) begin
                seen = 1'b1;
            end
            auto_blank[i] = !seen;
        end
    end
`else
    assign auto_blank = '0;
`endif

    assign eff_blank = shadow_blank | auto_blank;

    // Select the active digit's fields by shifting, so any NUM_DIGITS works.
    assign value_sel      = shadow_value >> {digit_idx, 2'b00};
    assign eff_blank_sel  = eff_blank >> digit_idx;
    assign user_blank_sel = shadow_blank >> digit_idx;
    assign dp_sel         = shadow_dp >> digit_idx;
    assign cur_nibble     = value_sel[3:0];

    hex_to_7seg u_dec (
        .nibble (cur_nibble),
        .seg    (cur_code)
    );

    // Auto-blanked digits keep their dp; only the explicit mask suppresses it.
    assign seg_on = eff_blank_sel[0] ? SEG_OFF : cur_code;
    assign dp_on  = dp_sel[0] && !user_blank_sel[0];
    // Ghost guard: the enable is dropped for the first cycle of every slot, which is
    // the cycle the registered segments still hold the previous digit.
    assign an_on  = terminal ? '0 : (NUM_DIGITS'(1) << digit_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= SEG_IDLE;
            dp  <= SEG_INV;
            an  <= AN_IDLE;
        end else begin
            seg <= seg_on ^ SEG_IDLE;
            dp  <= dp_on ^ SEG_INV;
            an  <= an_on ^ AN_IDLE;
        end
    end

endmodule

// File: tb/tb_display_7seg_scan.sv
// tb/tb_display_7seg_scan.sv - randomized self-checking bench for display_7seg_scan
module tb_display_7seg_scan;

    localparam int N = 4;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        update_ack;

    always #5 clk = ~clk;

    display_7seg_scan #(
        .NUM_DIGITS     (N),
        .REFRESH_DIV    (R),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .digit_idx  (digit_idx),
        .update_ack (update_ack)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: time since reset, pending and shown words.
    int          m_t;
    bit          m_pv;
    logic [15:0] m_pval, m_sval;
    logic [3:0]  m_pbl, m_pdp, m_sbl, m_sdp;
    bit          m_ack;
    logic [6:0]  code_tbl [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0d", tag, got, exp, m_t);
        end
    endtask

    function automatic logic [3:0] lz_mask(input logic [15:0] v);
        logic [3:0] m;
        int hi;
        m  = '0;
        hi = 0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 0; i < N; i++)
            if (v[4*i +: 4] != 4'h0) hi = i;
        for (int i = 0; i < N; i++)
            m[i] = (i > hi);
`endif
        return m;
    endfunction

    task automatic cycle();
        bit          bnd;
        int          d, p;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dp;
        logic [3:0]  nib;
        logic [3:0]  blk;
        @(posedge clk);
        if (reset) begin
            m_t = 0; m_pv = 0; m_ack = 0;
            m_pval = '0; m_sval = '0;
            m_pbl = '0; m_pdp = '0; m_sbl = '0; m_sdp = '0;
        end else begin
            bnd   = ((m_t % R) == R - 1) && (((m_t / R) % N) == N - 1);
            m_ack = 0;
            if (bnd && m_pv) begin
                m_sval = m_pval; m_sbl = m_pbl; m_sdp = m_pdp;
                m_pv = 0; m_ack = 1;
            end
            if (load) begin
                m_pval = value; m_pbl = blank_mask; m_pdp = dp_mask;
                m_pv = 1;
            end
            m_t++;
        end
        @(negedge clk);
        d = (m_t / R) % N;
        p = m_t % R;
        check("digit_idx", digit_idx, d);
        check("update_ack", update_ack, m_ack);
        if (reset) begin
            check("rst_seg", seg, 7'h7F);
            check("rst_dp", dp, 1'b1);
        end
        if (p == 0) begin
            check("an_guard", an, 4'hF);
        end else begin
            exp_an = 4'b0001 << d;
            exp_an = ~exp_an;
            check("an", an, exp_an);
            nib = m_sval[4*d +: 4];
            blk = m_sbl | lz_mask(m_sval);
            exp_seg = blk[d] ? 7'h7F : ~code_tbl[nib];
            exp_dp  = (m_sdp[d] && !m_sbl[d]) ? 1'b0 : 1'b1;
            check("seg", seg, exp_seg);
            check("dp", dp, exp_dp);
        end
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic put(input logic [15:0] v, input logic [3:0] b, input logic [3:0] dm);
        load = 1'b1; value = v; blank_mask = b; dp_mask = dm;
        cycle();
    endtask

    initial begin
        bit found;
        logic [15:0] vm;
        code_tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                     7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                     7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                     7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        m_t = 0;
        reset = 1'b1; load = 1'b0; value = '0; blank_mask = '0; dp_mask = '0;
        run(3);
        reset = 1'b0;
        run(20);
        // mid-frame load, then two loads inside one frame
        put(16'h1234, 4'b0000, 4'b0000);
        run(30);
        put(16'h1111, 4'b0000, 4'b0000);
        run(2);
        put(16'hABCD, 4'b0000, 4'b0000);
        run(30);
        put(16'h5678, 4'b0100, 4'b0010);
        run(34);
        put(16'h0005, 4'b0000, 4'b0100);
        run(34);
        put(16'h0000, 4'b0000, 4'b0000);
        run(34);
        // load on the boundary cycle, then reset mid-frame
        put(16'h4321, 4'b0000, 4'b0000);
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            if ((m_t % (R * N)) == R * N - 1) found = 1;
            else cycle();
        end
        check("align", found, 1'b1);
        put(16'h9876, 4'b0000, 4'b0000);
        run(6);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run(40);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
            else reset = 1'b0;
            if ($urandom_range(0, 11) == 0) begin
                vm = 16'hFFFF >> (4 * $urandom_range(0, 4));
                load = 1'b1;
                value = 16'($urandom) & vm;
                blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                dp_mask = 4'($urandom);
            end
            cycle();
        end
        reset = 1'b0;
        run(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
